bitboard_scan: RTL and testbench
================================

// Module: bitboard_scan
// PURPOSE
//  Expands a 64-bit board mask into a stream of square indices, one per set bit.
//  Default order is ascending (lowest set bit first).
//  It is the expanding counterpart of the popcount reducer.
//  Sits after move generation: it feeds legal-move squares to the search/flip stage.
//  Valid/ready on both the input and output sides; throughput is one index per cycle.
// PARAMETERS
//  WIDTH  64               mask width in bits (power of two, >=2)
//  IDXW   $clog2(WIDTH)    index width (6 at default)
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_bits is valid
//  in_ready   out  1      block can accept a mask
//  in_bits    in   WIDTH  mask to scan
//  abort      in   1      sync: discard remaining indices of the current mask
//  out_valid  out  1      out_idx/out_last/out_empty are valid
//  out_ready  in   1      consumer accepts the current beat
//  out_idx    out  IDXW   square index of the current set bit
//  out_last   out  1      current beat is the final beat for this mask
//  out_empty  out  1      mask had no bits set (single marker beat)
//  busy       out  1      block is in SCAN state
// BEHAVIOUR
//  - Reset (async assert, sync release to the clk domain):
//    - state=IDLE, remaining register rem=0.
//    - out_valid=0, out_idx=0, out_last=0, out_empty=0, busy=0, in_ready=1.
//    - Handshakes are ignored while rst_n=0.
//    - Reset mid-scan drops all pending indices; no beat is emitted after release.
//  - FSM, two states:
//    - IDLE: in_ready=1, out_valid=0.
//      - On in_valid & in_ready: rem<=in_bits, go to SCAN.
//    - SCAN: in_ready=0, out_valid=1, busy=1.
//      - out_idx is the index of the lowest set bit of rem.
//      - out_last = (rem & (rem-1))==0.
//      - out_empty = (rem==0).
//      - On out_valid & out_ready: clear that bit in rem. If out_last, go to IDLE.
//  - Empty mask: exactly one beat with out_empty=1, out_last=1, out_idx=0. Then IDLE.
//  - Latency: the first beat is valid the cycle after input acceptance.
//    - N set bits give N beats (1 beat if empty).
//    - With out_ready held at 1, the scan takes max(N,1) cycles.
//  - A new mask is accepted only in IDLE.
//    - Minimum cycle gap between masks: last beat consumed -> in_ready=1 the next cycle.
//  - Outputs are stable while out_valid=1 and out_ready=0.
//  - abort in SCAN: go to IDLE next cycle, rem<=0.
//    - abort beats a simultaneous out handshake: that beat counts as consumed, nothing further is emitted.
//    - abort in IDLE has no effect; in_valid in the same cycle is still accepted.
//  - Index encoding: priority encoder over rem, no arithmetic wrap.
//    - Bit 63 gives out_idx=63.
// CONFIGURATION
//  BITSCAN_MSB_FIRST_EN
//    - Defined: descending order. out_idx is the highest set bit of rem, and that bit is cleared on handshake.
//    - out_last and out_empty rules are unchanged.
//    - Not defined: ascending order as specified above.
//  Both builds must produce the same set of indices and the same beat count.
// TESTING
//  1. in_bits=64'h0000_0000_0000_0000, out_ready=1
//     -> one beat: out_empty=1, out_last=1, out_idx=0; in_ready=1 the next cycle.
//  2. in_bits=64'h8000_0000_0000_0011, out_ready=1
//     -> idx 0, 4, 63 on consecutive cycles; out_last only on 63.
//     -> With BITSCAN_MSB_FIRST_EN: 63, 4, 0.
//  3. in_bits=64'hFFFF_FFFF_FFFF_FFFF, random out_ready stalls
//     -> 64 beats with idx 0..63 in order; out_idx is stable across stalls.
//  4. in_bits=64'h0000_0000_0000_0F00, abort asserted with the handshake of idx 9
//     -> idx 8, 9 seen; nothing more; in_ready=1 the next cycle.
//  5. rst_n pulsed low during the scan of 64'h00F0
//     -> out_valid=0 immediately; after release in_ready=1 and no stale beat.
//  6. Back-to-back masks 64'h1 then 64'h2, with in_valid held
//     -> beats idx0(last), idx1(last); the second mask is accepted the cycle after the first last beat.

Source files
------------

// File: rtl/bitboard_scan.sv
// Expands a WIDTH-bit mask into one square index per set bit, valid/ready on both sides.
// Optional BITSCAN_MSB_FIRST_EN selects descending order (highest set bit first).
module bitboard_scan #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bits,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             out_empty,
   output logic             busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] rem;
   logic [IDXW-1:0]  sel;
   logic             rem_last;
   logic             rem_empty;

   // Priority encoder: the last matching iteration wins, so loop order sets the priority.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef BITSCAN_MSB_FIRST_EN
         if (rem[i]) sel = IDXW'(i);
`else
         if (rem[WIDTH-1-i]) sel = IDXW'(WIDTH-1-i);
`endif
      end
   end

   assign rem_last  = ((rem & (rem - WIDTH'(1))) == '0);
   assign rem_empty = (rem == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = SCAN;
         SCAN: if (abort || (out_ready && rem_last)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
      end else if (state == IDLE) begin
         if (in_valid) rem <= in_bits;
      end else if (abort) begin
         rem <= '0;
      end else if (out_ready) begin
         rem <= rem & ~(WIDTH'(1) << sel);
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == SCAN);
      busy      = (state == SCAN);
      out_idx   = (state == SCAN) ? sel : '0;
      out_last  = (state == SCAN) && rem_last;
      out_empty = (state == SCAN) && rem_empty;
   end

endmodule

// File: tb/tb_bitboard_scan.sv
// Directed plus randomized bench for bitboard_scan; expected beats come from a per-mask index list.
module tb_bitboard_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_bits = '0;
   logic        abort = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  out_idx;
   logic        out_last;
   logic        out_empty;
   logic        busy;

   int checks = 0;
   int errors = 0;

   bitboard_scan #(.WIDTH(64), .IDXW(6)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last), .out_empty(out_empty), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: list of set-bit positions in emission order.
   function automatic void expected_list(input logic [63:0] m, output int q[$]);
      q = {};
      for (int i = 0; i < 64; i++) if (m[i]) q.push_back(i);
`ifdef BITSCAN_MSB_FIRST_EN
      q.reverse();
`endif
   endfunction

   // Accept mask, then consume beats. abort_k >= 0 raises abort with beat abort_k.
   task automatic scan(input logic [63:0] m, input bit stall, input int abort_k, input string tag);
      int q[$];
      int n, k, budget;
      logic [5:0] e;
      expected_list(m, q);
      n = (m == 0) ? 1 : q.size();
      budget = 0;
      while (!in_ready && budget < 20) begin @(negedge clk); budget++; end
      chk({tag, "_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_bits  = m;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      budget = 0;
      while (k < n && budget < 1000) begin
         e = (m == 0) ? 6'd0 : 6'(q[k]);
         chk({tag, "_valid"}, out_valid, 1'b1);
         chk({tag, "_busy"},  busy, 1'b1);
         chk({tag, "_idx"},   out_idx, e);
         chk({tag, "_last"},  out_last, (k == n - 1));
         chk({tag, "_empty"}, out_empty, (m == 0));
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (k == abort_k) begin
            out_ready = 1'b1;
            abort = 1'b1;
         end
         @(negedge clk);
         abort = 1'b0;
         if (k == abort_k) begin k = n; break; end
         if (out_ready) k++;
         budget++;
      end
      out_ready = 1'b0;
      chk({tag, "_beats"}, k, n);
      chk({tag, "_done_ready"}, in_ready, 1'b1);
      chk({tag, "_done_valid"}, out_valid, 1'b0);
   endtask

   initial begin
      logic [63:0] m;
      // Reset state
      #2;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_busy",  busy, 1'b0);
      chk("rst_idx",   out_idx, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. Empty mask
      scan(64'h0, 1'b0, -1, "empty");
      // 2. Sparse mask including bit 63
      scan(64'h8000_0000_0000_0011, 1'b0, -1, "sparse");
      // 3. Full mask with random stalls
      scan(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, "full");
      // 4. Abort together with the second beat
      scan(64'h0000_0000_0000_0F00, 1'b0, 1, "abort");

      // 5. Reset pulse mid-scan
      in_valid = 1'b1; in_bits = 64'h00F0;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rst_mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid, 1'b0);
      chk("rst_mid_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_stale_valid", out_valid, 1'b0);
      end
      out_ready = 1'b0;

      // 6. Back-to-back masks with in_valid held
      in_valid = 1'b1; in_bits = 64'h1;
      @(negedge clk);
      in_bits = 64'h2; out_ready = 1'b1;
      chk("b2b_idx0", out_idx, 6'd0);
      chk("b2b_last0", out_last, 1'b1);
      chk("b2b_ready0", in_ready, 1'b0);
      @(negedge clk);
      chk("b2b_gap_ready", in_ready, 1'b1);
      chk("b2b_gap_valid", out_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_valid1", out_valid, 1'b1);
      chk("b2b_idx1", out_idx, 6'd1);
      chk("b2b_last1", out_last, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_end_ready", in_ready, 1'b1);

      // abort in IDLE must not block a simultaneous acceptance
      abort = 1'b1; in_valid = 1'b1; in_bits = 64'h5;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk("idle_abort_valid", out_valid, 1'b1);
      chk("idle_abort_idx", out_idx, 6'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_clear", out_valid, 1'b0);

      // Randomized masks, sparse and dense, some with abort
      for (int t = 0; t < 40; t++) begin
         m = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: m = m & {$urandom, $urandom} & {$urandom, $urandom};
            1: m = 64'h1 << $urandom_range(0, 63);
            2: m = ($urandom_range(0, 2) == 0) ? 64'h0 : m;
            default: ;
         endcase
         scan(m, 1'b1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
